medidor_pulsos: RTL and testbench
=================================

Name: medidor_pulsos

Overview:
Measures wheel-sensor pulse rate for the speedometer. Counts debounced rising edges of the raw sensor input over windows bounded by edges of the slow square-wave time base produced by the seconds divider. Each edge of the time base closes one window, publishes the count with a one-cycle valid strobe, and opens the next window. Sits between the time base and the display/speed-conversion logic.

Parameters:
CNT_W, 16, width of the pulse accumulator and of count_out
DEB_CYCLES, 1000, consecutive clock cycles a new sensor level must persist before it is accepted (minimum 1)
DEB_W, 10, width of the debounce counter; must satisfy 2^DEB_W >= DEB_CYCLES

Ports:
clock  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  measurement enable (synchronous to clock)
gate  input  1  time-base square wave, asynchronous to clock; each edge (either direction) ends a window
sensor  input  1  raw wheel-sensor signal, asynchronous, bouncy
count_out  output  CNT_W  pulse count of the last completed window
valid  output  1  one-cycle strobe when count_out updates
overflow  output  1  set when the last completed window saturated

Behaviour:
- Reset (reset_n low, asynchronous): all synchronizers, debounce state, accumulator and saturation flag go to 0; count_out=0, valid=0, overflow=0; FSM=IDLE. Reset may occur mid-window; the partial window is discarded and no valid is issued.
- Synchronizers: gate and sensor each pass through 2 flops (s1, s2). gate also has a delay flop g_d; gate edge event = g_s2 XOR g_d.
- Latency: if E0 is the first clock edge that samples a new gate level, the edge event is true between E1 and E2, and count_out/overflow/valid update at E2. valid is high for exactly the one cycle after E2.
- Debounce: deb_state holds the accepted sensor level, and deb_cnt counts mismatches. If sensor_s2 == deb_state, then deb_cnt<=0. Otherwise deb_cnt increments. When deb_cnt reaches DEB_CYCLES-1 while the mismatch persists, deb_state<=sensor_s2 and deb_cnt<=0. The debouncer runs in all FSM states.
- Pulse event: deb_state going 0->1 on a clock edge. Falling transitions are not counted.
- Accumulator: on a pulse event in MEASURE, acc<=acc+1 if acc is below all-ones. At all-ones, acc holds and sat<=1. There is no wrap-around.
- FSM states:
  IDLE: acc=0 and sat=0. Pulse events are ignored. On a gate edge event with enable=1, go to MEASURE with no valid. The first, partial window after reset or enable is never published.
  MEASURE: accumulate. On a gate edge event: count_out<=acc', overflow<=sat', valid<=1, acc<=0, sat<=0, and the FSM stays in MEASURE. acc' and sat' include a pulse event occurring in the same cycle, which counts into the closing window with saturation applied.
  Any state with enable=0: go to IDLE, acc<=0, sat<=0, valid<=0. count_out and overflow hold their last values.
- enable=0 and a gate edge event in the same cycle: enable wins, and no valid is issued.
- Gate edges in consecutive cycles each close a window. A window may be published with count 0.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
1. CNT_W=4, DEB_CYCLES=4, enable=1. Release reset, toggle gate, apply 5 clean sensor pulses (each level held 10 cycles), then toggle gate -> no valid on first toggle; on second toggle valid pulses 1 cycle at E2 with count_out=5, overflow=0.
2. Sensor glitches of 1-3 cycles high between windows, with otherwise clean pulses -> glitches not counted; a 4-cycle-high pulse counts as 1.
3. 20 clean pulses in one window with CNT_W=4 -> count_out=15, overflow=1. Next window with 2 pulses -> count_out=2, overflow=0.
4. A pulse event in the same cycle as the gate edge event, with 3 prior pulses -> count_out=4; the next window starts at 0.
5. Assert reset_n low mid-window after 7 pulses, asynchronously between clock edges -> outputs 0 immediately. After release, the first gate toggle gives no valid, and the next gives only pulses from the new window.
6. Drop enable mid-window, then re-raise it -> no valid while low and count_out holds its prior value. After re-enable, the first gate edge arms only, and the second publishes.

Source files
------------

// File: rtl/medidor_pulsos.sv
// medidor_pulsos: counts debounced rising edges of a wheel sensor
// between edges of a slow time-base gate.
//
// Ports:
//   clock     system clock, all state on its rising edge
//   reset_n   asynchronous active-low reset
//   enable    measurement enable (synchronous)
//   gate      time-base square wave (async); every edge closes a window
//   sensor    raw bouncy wheel sensor (async)
//   count_out pulse count of the last completed window
//   valid     one-cycle strobe when count_out updates
//   overflow  last completed window saturated
module medidor_pulsos #(
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 1000,
  parameter int DEB_W      = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             gate,
  input  logic             sensor,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             overflow
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  localparam logic [DEB_W-1:0] DEB_MAX =
    DEB_W'(DEB_CYCLES - 1);

  logic g_s1, g_s2, g_d;
  logic s_s1, s_s2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      g_s1 <= 1'b0;
      g_s2 <= 1'b0;
      g_d  <= 1'b0;
      s_s1 <= 1'b0;
      s_s2 <= 1'b0;
    end else begin
      g_s1 <= gate;
      g_s2 <= g_s1;
      g_d  <= g_s2;
      s_s1 <= sensor;
      s_s2 <= s_s1;
    end
  end

  logic gate_evt;
  assign gate_evt = g_s2 ^ g_d;

  logic             deb_state;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_flip;
  logic             pulse;

  // The accepted level flips on the edge where the mismatch
  // has lasted DEB_CYCLES samples; a 0->1 flip is a pulse.
  assign deb_flip = (s_s2 != deb_state)
                  && (deb_cnt == DEB_MAX);
  assign pulse    = deb_flip & s_s2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_state <= 1'b0;
      deb_cnt   <= '0;
    end else if (s_s2 == deb_state) begin
      deb_cnt   <= '0;
    end else if (deb_flip) begin
      deb_state <= s_s2;
      deb_cnt   <= '0;
    end else begin
      deb_cnt   <= deb_cnt + DEB_W'(1);
    end
  end

  logic [0:0]       state;
  logic [CNT_W-1:0] acc;
  logic             sat;
  logic             acc_full;
  logic [CNT_W-1:0] acc_nx;
  logic             sat_nx;
  logic             meas;

  // acc_nx/sat_nx fold in a pulse landing on this very edge,
  // so a closing window still sees it.
  assign meas     = (state == MEASURE);
  assign acc_full = &acc;
  assign acc_nx   = (pulse && !acc_full)
                  ? acc + CNT_W'(1) : acc;
  assign sat_nx   = sat | (pulse & acc_full);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      sat       <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (1'b1)
        !enable: begin
          state <= IDLE;
          acc   <= '0;
          sat   <= 1'b0;
        end
        enable && gate_evt && meas: begin
          count_out <= acc_nx;
          overflow  <= sat_nx;
          valid     <= 1'b1;
          acc       <= '0;
          sat       <= 1'b0;
        end
        enable && gate_evt && !meas: begin
          state <= MEASURE;
          acc   <= '0;
          sat   <= 1'b0;
        end
        enable && !gate_evt && meas: begin
          acc <= acc_nx;
          sat <= sat_nx;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_medidor_pulsos.sv
// tb_medidor_pulsos: directed and random stimulus for medidor_pulsos
// against a window-count reference model.
module tb_medidor_pulsos;

  localparam int CNT_W = 4;
  localparam int DEB   = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             gate = 1'b0;
  logic             sensor = 1'b0;
  logic [CNT_W-1:0] count_out;
  logic             valid;
  logic             overflow;

  medidor_pulsos #(
    .CNT_W(CNT_W),
    .DEB_CYCLES(DEB),
    .DEB_W(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .gate(gate),
    .sensor(sensor),
    .count_out(count_out),
    .valid(valid),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: inputs reach the core two edges after sampling.
  // Accepted level = value held for DEB consecutive samples.
  // Each gate change closes a window; count saturates at MAXC.
  bit gq[3];
  bit sq[3];
  bit deb_lvl;
  int run;
  bit last_s;
  bit armed;
  int win;
  int m_cnt;
  bit m_ovf;
  bit m_valid;

  task automatic model_step();
    bit s;
    bit ev;
    bit p;
    s = sq[1];
    ev = gq[1] ^ gq[2];
    p = 1'b0;
    if (s == last_s) run++;
    else run = 1;
    last_s = s;
    if (s != deb_lvl && run == DEB) begin
      deb_lvl = s;
      p = s;
    end
    m_valid = 1'b0;
    if (!enable) begin
      armed = 1'b0;
      win = 0;
    end else if (ev) begin
      if (armed) begin
        win += int'(p);
        m_cnt = (win > MAXC) ? MAXC : win;
        m_ovf = (win > MAXC);
        m_valid = 1'b1;
      end
      armed = 1'b1;
      win = 0;
    end else if (armed && p) begin
      win++;
    end
    for (int k = 2; k > 0; k--) begin
      gq[k] = gq[k-1];
      sq[k] = sq[k-1];
    end
    gq[0] = gate;
    sq[0] = sensor;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      gq[k] = 1'b0;
      sq[k] = 1'b0;
    end
    deb_lvl = 1'b0;
    run = 0;
    last_s = 1'b0;
    armed = 1'b0;
    win = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      chk("valid", int'(valid), int'(m_valid));
      chk("count", int'(count_out), m_cnt);
      chk("ovf", int'(overflow), int'(m_ovf));
    end
  end

  task automatic pulse(input int hi, input int lo);
    sensor = 1'b1;
    repeat (hi) @(negedge clock);
    sensor = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic pulses(input int n, input int w);
    for (int i = 0; i < n; i++) pulse(w, w);
  endtask

  task automatic toggle();
    gate = ~gate;
  endtask

  task automatic expect_pub(input string tag,
                            input int c, input int o);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clock);
      if (valid) begin
        seen = 1'b1;
        chk({tag, "_cnt"}, int'(count_out), c);
        chk({tag, "_ovf"}, int'(overflow), o);
      end
    end
    chk({tag, "_seen"}, int'(seen), 1);
  endtask

  task automatic expect_none(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (valid) seen = 1'b1;
    end
    chk(tag, int'(seen), 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_cnt", int'(count_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset_n = 1'b1;
    enable = 1'b1;
    @(negedge clock);

    toggle();
    expect_none("t1_arm", 6);
    pulses(5, 10);
    toggle();
    expect_pub("t1", 5, 0);

    pulse(1, 6);
    pulse(2, 6);
    pulse(3, 6);
    pulse(4, 8);
    pulse(10, 10);
    toggle();
    expect_pub("t2", 2, 0);

    pulses(20, 5);
    toggle();
    expect_pub("t3_sat", 15, 1);
    pulses(2, 6);
    toggle();
    expect_pub("t3_next", 2, 0);

    pulses(3, 6);
    sensor = 1'b1;
    repeat (3) @(negedge clock);
    toggle();
    expect_pub("t4", 4, 0);
    repeat (5) @(negedge clock);
    sensor = 1'b0;
    repeat (8) @(negedge clock);
    toggle();
    expect_pub("t4_next", 0, 0);

    pulses(7, 5);
    toggle();
    expect_pub("t5_pre", 7, 0);
    pulses(7, 5);
    sensor = 1'b1;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_cnt", int'(count_out), 0);
    chk("t5_rst_valid", int'(valid), 0);
    chk("t5_rst_ovf", int'(overflow), 0);
    sensor = 1'b0;
    gate = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    toggle();
    expect_none("t5_arm", 8);
    pulses(2, 5);
    toggle();
    expect_pub("t5", 2, 0);

    pulses(3, 5);
    enable = 1'b0;
    toggle();
    expect_none("t6_off", 8);
    chk("t6_hold", int'(count_out), 2);
    enable = 1'b1;
    toggle();
    expect_none("t6_arm", 6);
    pulse(5, 5);
    toggle();
    expect_pub("t6", 1, 0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 3) == 0) sensor = ~sensor;
      if ($urandom_range(0, 59) == 0) toggle();
      if ($urandom_range(0, 399) == 0) enable = ~enable;
    end
    enable = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 5) == 0) sensor = ~sensor;
      if ($urandom_range(0, 299) == 0) toggle();
      if ($urandom_range(0, 999) == 0) toggle();
    end
    repeat (4) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
